// File: rtl/stopwatch_pkg.sv
// Shared constants, FSM encoding and BCD-to-ASCII helper for the lap UART transmitter.
// Build option LAP_INDEX_EN lengthens each record with a "n:" lap-number prefix.
package stopwatch_pkg;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

`ifdef LAP_INDEX_EN
  localparam int REC_LEN = 9;
`else
  localparam int REC_LEN = 7;
`endif

  function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_QMARK : ASCII_ZERO + {4'd0, d};
  endfunction
endpackage

// File: rtl/lap_uart_tx_if.sv
// Lap-record push port: valid/ready handshake plus synchronous flush.
interface lap_uart_tx_if;
  logic [15:0] lap_data;
  logic        lap_valid;
  logic        lap_ready;
  logic        lap_clr;

  modport master (output lap_data, lap_valid, lap_clr, input lap_ready);
  modport slave  (input lap_data, lap_valid, lap_clr, output lap_ready);
endinterface

// File: rtl/lap_uart_tx_byte.sv
// 8N1 byte serialiser; a start seen on the last stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
  import stopwatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       active,
  output logic       txd
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;

  assign tick   = (timer == T_LAST);
  assign done   = (state == ST_STOP) && tick;
  assign active = (state != ST_IDLE);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      timer <= (state == ST_IDLE || tick) ? '0 : timer + 1'b1;
      case (state)
        ST_IDLE: if (start) begin
          shreg <= data;
          state <= ST_START;
          txd   <= 1'b0;
        end
        ST_START: if (tick) begin
          state   <= ST_DATA;
          bit_idx <= '0;
          txd     <= shreg[0];
        end
        ST_DATA: if (tick) begin
          if (bit_idx == 3'd7) begin
            state <= ST_STOP;
            txd   <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {1'b0, shreg[7:1]};
            txd     <= shreg[1];
          end
        end
        default: if (tick) begin
          if (start) begin
            shreg <= data;
            state <= ST_START;
            txd   <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/lap_uart_tx.sv
// Lap record FIFO + ASCII sequencer feeding an 8N1 serialiser ("SS.CC\r\n" per record).
// Build option LAP_INDEX_EN prefixes each record with "n:" (n = 1..9, cycling).
module lap_uart_tx
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 9
) (
  input  logic            clock,
  input  logic            rst,
  lap_uart_tx_if.slave    lap,
  output logic            txd,
  output logic            busy,
  output logic [3:0]      level,
  output logic            overflow
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [3:0] DEPTH_L   = 4'(DEPTH);
  localparam logic [3:0] LAST_CHAR = 4'(REC_LEN - 1);
  localparam logic [3:0] OFS       = 4'(REC_LEN - 7);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   rec, char_rec;
  logic [3:0]    char_idx, char_num;
  logic [7:0]    char_sel;
  logic          in_rec, push, pop, more, start, done, active;
`ifdef LAP_INDEX_EN
  logic [3:0]    lap_cnt;
`endif

  assign lap.lap_ready = (level != DEPTH_L);
  assign push  = lap.lap_valid && lap.lap_ready && !lap.lap_clr;
  // New records start only from idle; later characters chain off each stop bit.
  assign pop   = !in_rec && (level != 4'd0) && !lap.lap_clr;
  assign more  = in_rec && (char_idx != LAST_CHAR);
  assign start = pop || (done && more);
  assign busy  = active || (level != 4'd0);

  assign char_rec = in_rec ? rec : mem[rd_ptr];
  assign char_num = in_rec ? char_idx + 4'd1 : 4'd0;

  always_comb begin
    char_sel = ASCII_LF;
    case (char_num)
`ifdef LAP_INDEX_EN
      4'd0:       char_sel = ASCII_ZERO + {4'd0, lap_cnt} + 8'd1;
      4'd1:       char_sel = ASCII_COLON;
`endif
      OFS:        char_sel = bcd2ascii(char_rec[15:12]);
      OFS + 4'd1: char_sel = bcd2ascii(char_rec[11:8]);
      OFS + 4'd2: char_sel = ASCII_DOT;
      OFS + 4'd3: char_sel = bcd2ascii(char_rec[7:4]);
      OFS + 4'd4: char_sel = bcd2ascii(char_rec[3:0]);
      OFS + 4'd5: char_sel = ASCII_CR;
      default:    char_sel = ASCII_LF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= lap.lap_data;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      rec      <= '0;
      in_rec   <= 1'b0;
      char_idx <= '0;
    end else begin
      if (lap.lap_clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 4'd1;
        else if (pop && !push) level <= level - 4'd1;
        if (lap.lap_valid && !lap.lap_ready) overflow <= 1'b1;
      end
      // A flush never touches the record already in flight.
      if (pop) begin
        rec      <= mem[rd_ptr];
        in_rec   <= 1'b1;
        char_idx <= '0;
      end else if (done) begin
        if (more) char_idx <= char_idx + 4'd1;
        else      in_rec   <= 1'b0;
      end
    end
  end

`ifdef LAP_INDEX_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)             lap_cnt <= '0;
    else if (lap.lap_clr) lap_cnt <= '0;
    else if (pop)         lap_cnt <= (lap_cnt == 4'd8) ? 4'd0 : lap_cnt + 4'd1;
  end
`endif

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clock  (clock),
    .rst    (rst),
    .start  (start),
    .data   (char_sel),
    .done   (done),
    .active (active),
    .txd    (txd)
  );
endmodule

// File: tb/tb_lap_uart_tx.sv
// Bench for lap_uart_tx: queue-based line model checked every cycle, plus decoded-byte literal checks.
module tb_lap_uart_tx;
  import stopwatch_pkg::*;
  localparam int CLK_HZ = 1000, BAUD = 100, DEPTH = 9;
  localparam int C   = CLK_HZ / BAUD;
  localparam int NCH = REC_LEN;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       txd, busy, overflow;
  logic [3:0] level;
  bit         chk_en = 1'b0;

  lap_uart_tx_if lif();

  lap_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clock(clock), .rst(rst), .lap(lif), .txd(txd), .busy(busy),
    .level(level), .overflow(overflow));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Text of a record, character k, written straight from the output format.
  function automatic logic [7:0] m_char(input logic [15:0] r, input int lapn, input int k);
    logic [7:0] s[$];
    logic [3:0] nib;
`ifdef LAP_INDEX_EN
    s.push_back(8'h30 + lapn[7:0]);
    s.push_back(8'h3A);
`endif
    for (int i = 3; i >= 0; i--) begin
      nib = r[4*i +: 4];
      if (i == 1) s.push_back(8'h2E);
      s.push_back(nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h3F);
    end
    s.push_back(8'h0D);
    s.push_back(8'h0A);
    return s[k];
  endfunction

  logic [15:0] mq[$];
  bit          line[$];
  bit          m_ovf = 1'b0;
  int          lapc  = 0;

  task automatic expand(input logic [15:0] r, input int lapn);
    logic [7:0] ch;
    for (int k = 0; k < NCH; k++) begin
      ch = m_char(r, lapn, k);
      repeat (C) line.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (C) line.push_back(ch[b]);
      repeat (C) line.push_back(1'b1);
    end
  endtask

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      mq.delete(); line.delete(); m_ovf = 1'b0; lapc = 0;
    end else begin
      bit was_empty, full;
      logic [15:0] r;
      was_empty = (line.size() == 0);
      full      = (mq.size() == DEPTH);
      if (!was_empty) void'(line.pop_front());
      if (lif.lap_clr) begin
        mq.delete(); m_ovf = 1'b0; lapc = 0;
      end else begin
        if (was_empty && mq.size() > 0) begin
          r = mq.pop_front();
          expand(r, lapc + 1);
          lapc = (lapc + 1) % 9;
        end
        if (lif.lap_valid && !full) mq.push_back(lif.lap_data);
        else if (lif.lap_valid)     m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("txd",       txd,           (line.size() > 0) ? 32'(line[0]) : 32'd1);
      check("level",     level,         mq.size());
      check("lap_ready", lif.lap_ready, mq.size() != DEPTH);
      check("busy",      busy,          (line.size() > 0) || (mq.size() > 0));
      check("overflow",  overflow,      m_ovf);
    end
  end

  task automatic push(input logic [15:0] d);
    @(negedge clock); lif.lap_data = d; lif.lap_valid = 1'b1;
    @(negedge clock); lif.lap_valid = 1'b0;
  endtask

  task automatic wait_fall(input string name, output int waited);
    waited = 0;
    while (txd !== 1'b0 && waited < 2000) begin @(negedge clock); waited++; end
    check({name, "_start_seen"}, txd, 0);
  endtask

  task automatic wait_idle(input string name, input int lim);
    int t = 0;
    while (busy !== 1'b0 && t < lim) begin @(negedge clock); t++; end
    check({name, "_idle"}, busy, 0);
  endtask

  // Samples one record off the line at mid-bit and compares the decoded bytes.
  task automatic rx_check(input string name, input int n, input logic [71:0] exp, output int waited);
    logic smp[NCH*10*C];
    logic [7:0] b;
    int base;
    wait_fall(name, waited);
    for (int i = 0; i < n*10*C; i++) begin smp[i] = txd; @(negedge clock); end
    for (int k = 0; k < n; k++) begin
      base = k*10*C;
      for (int j = 0; j < 8; j++) b[j] = smp[base + (j+1)*C + C/2];
      check({name, "_startbit"}, smp[base + C/2], 0);
      check({name, "_stopbit"},  smp[base + 9*C + C/2], 1);
      check({name, "_byte"}, b, exp[8*(n-1-k) +: 8]);
    end
    check({name, "_last_stop_cycle"}, smp[n*10*C - 1], 1);
    check({name, "_gap_high"}, txd, 1);
  endtask

  initial begin
    int w;
    logic [55:0] pin;
    lif.lap_data = '0; lif.lap_valid = 1'b0; lif.lap_clr = 1'b0;
    #7 chk_en = 1'b1;
    repeat (3) @(negedge clock);
    rst = 1'b1;

    pin = {"12.34", 8'h0D, 8'h0A};
    for (int k = 0; k < 7; k++) check("model_pin_1234", m_char(16'h1234, 1, k + NCH - 7), pin[8*(6-k) +: 8]);
    pin = {"5?.09", 8'h0D, 8'h0A};
    for (int k = 0; k < 7; k++) check("model_pin_5A09", m_char(16'h5A09, 1, k + NCH - 7), pin[8*(6-k) +: 8]);

`ifndef LAP_INDEX_EN
    push(16'h1234);
    check("txd_high_after_push_edge", txd, 1);
    rx_check("rec1234", 7, {16'h0, "12.34", 8'h0D, 8'h0A}, w);
    check("start_latency", w, 1);
    check("busy_after_record", busy, 0);
    push(16'h5A09);
    rx_check("rec5A09", 7, {16'h0, "5?.09", 8'h0D, 8'h0A}, w);
`endif

    // Asynchronous reset in the middle of a start bit.
    push(16'h9876);
    wait_fall("rst_mid", w);
    #2 rst = 1'b0;
    #1;
    check("rst_async_txd", txd, 1);
    check("rst_async_level", level, 0);
    check("rst_async_ready", lif.lap_ready, 1);
    check("rst_async_busy", busy, 0);
    repeat (3) @(negedge clock);
    rst = 1'b1;
    repeat (40) @(negedge clock);

`ifdef LAP_INDEX_EN
    push(16'h0001);
    push(16'h0001);
    rx_check("lap1", 9, {"1:00.01", 8'h0D, 8'h0A}, w);
    rx_check("lap2", 9, {"2:00.01", 8'h0D, 8'h0A}, w);
`endif

    // Eleven back-to-back offers into an idle block.
    @(negedge clock);
    lif.lap_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      lif.lap_data = 16'($urandom);
      @(negedge clock);
      if (i == 9) begin
        check("fill_level9", level, 9);
        check("fill_not_ready", lif.lap_ready, 0);
        check("fill_no_ovf_yet", overflow, 0);
      end
      if (i == 10) check("fill_overflow", overflow, 1);
    end
    lif.lap_valid = 1'b0;
    wait_idle("fill_drain", 12*10*C*NCH);

    // Flush with one record on the line and four queued.
    lif.lap_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin lif.lap_data = 16'($urandom); @(negedge clock); end
    lif.lap_valid = 1'b0;
    check("flush_pre_level", level, 4);
    check("flush_pre_ovf_sticky", overflow, 1);
    lif.lap_clr = 1'b1; lif.lap_valid = 1'b1; lif.lap_data = 16'h4242;
    @(negedge clock);
    lif.lap_clr = 1'b0; lif.lap_valid = 1'b0;
    check("flush_level", level, 0);
    check("flush_ovf", overflow, 0);
    check("flush_record_continues", busy, 1);
    wait_idle("flush_drain", 20*C*NCH);
    repeat (30) @(negedge clock);

    // Random offers, then drain.
    for (int i = 0; i < 3000; i++) begin
      lif.lap_valid = ($urandom_range(0, 99) < 3);
      lif.lap_data  = 16'($urandom);
      @(negedge clock);
    end
    lif.lap_valid = 1'b0;
    wait_idle("random_drain", 12*10*C*NCH);
    repeat (5) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
